sfx_sequencer: RTL



---
 rtl/sfx_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
// sfx_sequencer
//   Turns one-cycle game event pulses (eat, die, start) into timed note
//   sequences for a square-wave tone generator.
//
//   Optional build macro: SFX_EVENT_QUEUE_EN
//     defined   -> a one-deep pending register holds an eat/start event that
//                  arrives while a sequence is playing; it starts right after
//                  DONE without passing through IDLE.
//     undefined -> eat/start events arriving while busy are dropped.
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     ev_eat     one-cycle pulse: food eaten
//     ev_die     one-cycle pulse: snake died (preempts eat/start)
//     ev_start   one-cycle pulse: game started
//     mute       level; forces tone_en low, timing unaffected
//     tone_half  half-period count for the tone generator (cycles - 1)
//     tone_en    high while a note sounds
//     busy       high from LOAD through the end of the sequence
//     seq_done   one-cycle pulse when a sequence completes or is preempted
//
//   state | meaning
//   IDLE  | waiting for an event
//   LOAD  | latch ROM note, clear ms prescaler and ms counter
//   PLAY  | note sounding for dur ms
//   GAP   | silent gap between notes
//   DONE  | sequence finished, seq_done pulses
module sfx_sequencer #(
  parameter int CYCLES_PER_MS = 100000,
  parameter int NOTE_W        = 20,
  parameter int DUR_W         = 10,
  parameter int GAP_MS        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_eat,
  input  logic              ev_die,
  input  logic              ev_start,
  input  logic              mute,
  output logic [NOTE_W-1:0] tone_half,
  output logic              tone_en,
  output logic              busy,
  output logic              seq_done
);

  localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEQ_EAT, SEQ_START, SEQ_DIE
  } seq_t;

  state_t             state;
  seq_t               seq_id;
  logic [1:0]         note_idx;
  logic [PRE_W-1:0]   presc;
  logic [DUR_W-1:0]   ms_cnt;
  logic [DUR_W-1:0]   cur_dur;

  logic [NOTE_W-1:0]  rom_half;
  logic [DUR_W-1:0]   rom_dur;
  logic [1:0]         last_idx;
  logic               ev_any;
  seq_t               ev_id;
  logic               presc_wrap;
  logic               in_seq;

`ifdef SFX_EVENT_QUEUE_EN
  logic               pend_valid;
  seq_t               pend_id;
`endif

  // Note ROM: (half-period count, duration in ms)
  always_comb begin
    rom_half = '0;
    rom_dur  = '0;
    case ({seq_id, note_idx})
      {SEQ_EAT,   2'd0}: begin rom_half = NOTE_W'(63775);  rom_dur = DUR_W'(60);  end
      {SEQ_EAT,   2'd1}: begin rom_half = NOTE_W'(47778);  rom_dur = DUR_W'(60);  end
      {SEQ_START, 2'd0}: begin rom_half = NOTE_W'(113635); rom_dur = DUR_W'(100); end
      {SEQ_START, 2'd1}: begin rom_half = NOTE_W'(90194);  rom_dur = DUR_W'(100); end
      {SEQ_START, 2'd2}: begin rom_half = NOTE_W'(75842);  rom_dur = DUR_W'(200); end
      {SEQ_DIE,   2'd0}: begin rom_half = NOTE_W'(113635); rom_dur = DUR_W'(150); end
      {SEQ_DIE,   2'd1}: begin rom_half = NOTE_W'(127550); rom_dur = DUR_W'(150); end
      {SEQ_DIE,   2'd2}: begin rom_half = NOTE_W'(143180); rom_dur = DUR_W'(150); end
      {SEQ_DIE,   2'd3}: begin rom_half = NOTE_W'(170264); rom_dur = DUR_W'(400); end
      default: begin rom_half = '0; rom_dur = '0; end
    endcase
  end

  always_comb begin
    last_idx = 2'd0;
    case (seq_id)
      SEQ_EAT:   last_idx = 2'd1;
      SEQ_START: last_idx = 2'd2;
      SEQ_DIE:   last_idx = 2'd3;
      default:   last_idx = 2'd0;
    endcase
  end

  // Priority on simultaneous pulses: die > start > eat
  always_comb begin
    ev_any = ev_die | ev_start | ev_eat;
    if (ev_die)        ev_id = SEQ_DIE;
    else if (ev_start) ev_id = SEQ_START;
    else               ev_id = SEQ_EAT;
  end

  assign presc_wrap = (presc == PRE_LAST);
  assign in_seq     = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      seq_id     <= SEQ_EAT;
      note_idx   <= '0;
      presc      <= '0;
      ms_cnt     <= '0;
      cur_dur    <= '0;
      tone_half  <= '0;
      tone_en    <= 1'b0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
`ifdef SFX_EVENT_QUEUE_EN
      pend_valid <= 1'b0;
      pend_id    <= SEQ_EAT;
`endif
    end else begin
      seq_done <= 1'b0;
      if (in_seq && ev_die && (seq_id != SEQ_DIE)) begin
        // Die aborts eat/start: report the abort now, load die note 0 next
        seq_done <= 1'b1;
        tone_en  <= 1'b0;
        seq_id   <= SEQ_DIE;
        note_idx <= '0;
        state    <= S_LOAD;
`ifdef SFX_EVENT_QUEUE_EN
        pend_valid <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (ev_any) begin
              seq_id   <= ev_id;
              note_idx <= '0;
              busy     <= 1'b1;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            tone_half <= rom_half;
            cur_dur   <= rom_dur;
            presc     <= '0;
            ms_cnt    <= '0;
            tone_en   <= ~mute;
            state     <= S_PLAY;
          end
          S_PLAY: begin
            tone_en <= ~mute;
            presc   <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap) begin
              if (ms_cnt == cur_dur - 1'b1) begin
                ms_cnt  <= '0;
                tone_en <= 1'b0;
                if (note_idx == last_idx) begin
                  seq_done <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  state <= S_GAP;
                end
              end else begin
                ms_cnt <= ms_cnt + 1'b1;
              end
            end
          end
          S_GAP: begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap) begin
              if (ms_cnt == GAP_LAST) begin
                ms_cnt   <= '0;
                note_idx <= note_idx + 1'b1;
                state    <= S_LOAD;
              end else begin
                ms_cnt <= ms_cnt + 1'b1;
              end
            end
          end
          S_DONE: begin
            // An event seen here starts the next sequence directly, so busy
            // stays high; otherwise drop back to IDLE.
            tone_en  <= 1'b0;
            note_idx <= '0;
            state    <= S_LOAD;
            if (ev_die) seq_id <= SEQ_DIE;
`ifdef SFX_EVENT_QUEUE_EN
            else if (pend_valid) seq_id <= pend_id;
`endif
            else if (ev_any) seq_id <= ev_id;
            else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`ifdef SFX_EVENT_QUEUE_EN
            pend_valid <= 1'b0;
`endif
          end
          default: begin
            state   <= S_IDLE;
            tone_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
`ifdef SFX_EVENT_QUEUE_EN
        // A pending start is never displaced by a later eat
        if (in_seq && (ev_start || ev_eat)) begin
          if (!pend_valid || (pend_id == SEQ_EAT)) begin
            pend_valid <= 1'b1;
            pend_id    <= ev_start ? SEQ_START : SEQ_EAT;
          end
        end
`endif
      end
    end
  end

endmodule
